// File: rtl/pipe_ctrl_if.sv
// Decode-side sequencer bus: instruction classification inputs, memory handshake
// and the pipeline control strobes driven back toward fetch/decode/execute.
interface pipe_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic [15:0]      i_ir;
   logic             i_ir_valid;
   logic             i_cond_pass;
   logic             i_mem_ready;
   logic             o_stall;
   logic             o_flush;
   logic             o_pc_we;
   logic             o_mem_req;
   logic             o_mem_we;
   logic             o_rf_we;
   logic             o_flags_we;
   logic             o_err;
   logic [2:0]       o_state;
   logic [CNT_W-1:0] o_retired;

   modport master (
      output i_ir, i_ir_valid, i_cond_pass, i_mem_ready,
      input  o_stall, o_flush, o_pc_we, o_mem_req, o_mem_we,
             o_rf_we, o_flags_we, o_err, o_state, o_retired
   );

   modport slave (
      input  i_ir, i_ir_valid, i_cond_pass, i_mem_ready,
      output o_stall, o_flush, o_pc_we, o_mem_req, o_mem_we,
             o_rf_we, o_flags_we, o_err, o_state, o_retired
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: classifies the decode word and sequences memory
// waits, branch flushes and write strobes for the 16-bit Thumb-subset core.
module pipe_ctrl #(
   parameter int unsigned MEM_TIMEOUT  = 16,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic         clk,
   input  logic         rst,
   pipe_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_MEM   = 3'd2,
      S_BR    = 3'd3,
      S_FLUSH = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_ALU, C_CMP, C_LD, C_ST, C_BR, C_UND
   } cls_t;

   state_t           r_state;
   logic [7:0]       r_tmo;
   logic [2:0]       r_fcnt;
   logic             r_is_ld;
   logic             r_mem_req;
   logic             r_mem_we;
   logic             r_rf_we;
   logic             r_flags_we;
   logic             r_pc_we;
   logic             r_flush;
   logic             r_err;
   logic [CNT_W-1:0] r_retired;
   cls_t             w_cls;
   logic             w_unused_ir;

   assign w_unused_ir = ^bus.i_ir[6:0];

   always_comb begin
      w_cls = C_UND;
      casez (bus.i_ir[15:7])
         9'b0001110??: w_cls = C_ALU;   // ADD
         9'b101100001: w_cls = C_ALU;   // SUB SP
         9'b00100????: w_cls = C_ALU;   // MOV imm
         9'b01000110?: w_cls = C_ALU;   // MOV reg
         9'b01101????: w_cls = C_LD;
         9'b01100????: w_cls = C_ST;
         9'b1101?????: w_cls = C_BR;
         9'b00101????: w_cls = C_CMP;
         default:      w_cls = C_UND;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_tmo      <= '0;
         r_fcnt     <= '0;
         r_is_ld    <= 1'b0;
         r_mem_req  <= 1'b0;
         r_mem_we   <= 1'b0;
         r_rf_we    <= 1'b0;
         r_flags_we <= 1'b0;
         r_pc_we    <= 1'b0;
         r_flush    <= 1'b0;
         r_err      <= 1'b0;
         r_retired  <= '0;
      end else begin
         r_rf_we    <= 1'b0;
         r_flags_we <= 1'b0;
         r_pc_we    <= 1'b0;
         case (r_state)
            S_IDLE: r_state <= S_RUN;
            S_RUN: begin
               if (bus.i_ir_valid) begin
                  case (w_cls)
                     C_ALU: begin
                        r_rf_we   <= 1'b1;
                        r_retired <= r_retired + CNT_W'(1);
                     end
                     C_CMP: begin
                        r_flags_we <= 1'b1;
                        r_retired  <= r_retired + CNT_W'(1);
                     end
                     C_LD, C_ST: begin
                        r_state   <= S_MEM;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= (w_cls == C_ST);
                        r_is_ld   <= (w_cls == C_LD);
                        r_tmo     <= '0;
                     end
                     C_BR: r_state <= S_BR;
                     default: begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                     end
                  endcase
               end
            end
            S_MEM: begin
               // Ready is checked first so a late acknowledge still beats the timeout.
               if (bus.i_mem_ready) begin
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_rf_we   <= r_is_ld;
                  r_retired <= r_retired + CNT_W'(1);
                  r_state   <= S_RUN;
               end else if (r_tmo == 8'(MEM_TIMEOUT - 1)) begin
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_err     <= 1'b1;
                  r_state   <= S_ERR;
               end else begin
                  r_tmo <= r_tmo + 8'd1;
               end
            end
            S_BR: begin
               r_retired <= r_retired + CNT_W'(1);
               if (bus.i_cond_pass) begin
                  r_pc_we <= 1'b1;
                  r_flush <= 1'b1;
                  r_fcnt  <= 3'(FLUSH_CYCLES - 1);
                  r_state <= S_FLUSH;
               end else begin
                  r_state <= S_RUN;
               end
            end
            S_FLUSH: begin
               if (r_fcnt == 3'd0) begin
                  r_flush <= 1'b0;
                  r_state <= S_RUN;
               end else begin
                  r_fcnt <= r_fcnt - 3'd1;
               end
            end
            S_ERR: begin
               r_err     <= 1'b1;
               r_mem_req <= 1'b0;
               r_mem_we  <= 1'b0;
               r_flush   <= 1'b0;
            end
            default: begin
               r_state <= S_ERR;
               r_err   <= 1'b1;
            end
         endcase
      end
   end

   assign bus.o_stall    = (r_state != S_RUN);
   assign bus.o_flush    = r_flush;
   assign bus.o_pc_we    = r_pc_we;
   assign bus.o_mem_req  = r_mem_req;
   assign bus.o_mem_we   = r_mem_we;
   assign bus.o_rf_we    = r_rf_we;
   assign bus.o_flags_we = r_flags_we;
   assign bus.o_err      = r_err;
   assign bus.o_state    = r_state;
   assign bus.o_retired  = r_retired;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hand-computed output vectors after each clock edge.
module tb_pipe_ctrl;

   logic clk;
   logic rst;
   int   n_total;
   int   n_bad;
   int   exp_ret;

   pipe_ctrl_if #(.CNT_W(16)) bus ();

   pipe_ctrl #(
      .MEM_TIMEOUT  (16),
      .FLUSH_CYCLES (2),
      .CNT_W        (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Vector order: state, stall, mem_req, mem_we, rf_we, flags_we, pc_we, flush, err
   task automatic chk_o(input string tag, input logic [2:0] st, input logic req,
                        input logic we, input logic rf, input logic fl,
                        input logic pc, input logic fls, input logic err);
      logic stall_exp;
      stall_exp = (st != 3'd1);
      chk(tag,
          {21'd0, bus.o_state, bus.o_stall, bus.o_mem_req, bus.o_mem_we, bus.o_rf_we,
           bus.o_flags_we, bus.o_pc_we, bus.o_flush, bus.o_err},
          {21'd0, st, stall_exp, req, we, rf, fl, pc, fls, err});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] alu_words [3];
      n_total = 0;
      n_bad   = 0;
      exp_ret = 0;
      alu_words[0] = 16'h1C08;  // ADD
      alu_words[1] = 16'hB081;  // SUB SP
      alu_words[2] = 16'h4608;  // MOV reg

      rst = 1'b0;
      bus.i_ir = '0;
      bus.i_ir_valid = 1'b0;
      bus.i_cond_pass = 1'b0;
      bus.i_mem_ready = 1'b0;
      tick();
      tick();
      chk_o("reset_outs", 3'd0, 0, 0, 0, 0, 0, 0, 0);
      chk("reset_ret", {16'd0, bus.o_retired}, 32'd0);

      // MOV imm
      rst = 1'b1;
      bus.i_ir = 16'h2005;
      bus.i_ir_valid = 1'b1;
      tick();
      chk_o("idle_to_run", 3'd1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      exp_ret = 1;
      chk_o("mov_rf_we", 3'd1, 0, 0, 1, 0, 0, 0, 0);
      chk("mov_ret", {16'd0, bus.o_retired}, 32'(exp_ret));

      for (int unsigned i = 0; i < 3; i++) begin
         bus.i_ir = alu_words[i];
         tick();
         exp_ret++;
         chk_o("alu_rf_we", 3'd1, 0, 0, 1, 0, 0, 0, 0);
         chk("alu_ret", {16'd0, bus.o_retired}, 32'(exp_ret));
      end
      bus.i_ir_valid = 1'b0;
      tick();
      chk_o("idle_valid0", 3'd1, 0, 0, 0, 0, 0, 0, 0);
      chk("valid0_ret", {16'd0, bus.o_retired}, 32'(exp_ret));

      // LDR, ready on third MEM cycle
      bus.i_ir = 16'h6808;
      bus.i_ir_valid = 1'b1;
      tick();
      bus.i_ir_valid = 1'b0;
      chk_o("ldr_mem1", 3'd2, 1, 0, 0, 0, 0, 0, 0);
      tick();
      chk_o("ldr_mem2", 3'd2, 1, 0, 0, 0, 0, 0, 0);
      tick();
      chk_o("ldr_mem3", 3'd2, 1, 0, 0, 0, 0, 0, 0);
      bus.i_mem_ready = 1'b1;
      tick();
      bus.i_mem_ready = 1'b0;
      exp_ret++;
      chk_o("ldr_done", 3'd1, 0, 0, 1, 0, 0, 0, 0);
      chk("ldr_ret", {16'd0, bus.o_retired}, 32'(exp_ret));
      tick();
      chk_o("ldr_after", 3'd1, 0, 0, 0, 0, 0, 0, 0);

      // STR, never acknowledged
      bus.i_ir = 16'h6008;
      bus.i_ir_valid = 1'b1;
      tick();
      bus.i_ir_valid = 1'b0;
      chk_o("str_mem1", 3'd2, 1, 1, 0, 0, 0, 0, 0);
      for (int unsigned i = 1; i < 16; i++) begin
         tick();
         chk_o("str_wait", 3'd2, 1, 1, 0, 0, 0, 0, 0);
      end
      tick();
      chk_o("str_timeout", 3'd5, 0, 0, 0, 0, 0, 0, 1);
      bus.i_ir = 16'h2005;
      bus.i_ir_valid = 1'b1;
      bus.i_mem_ready = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         tick();
         chk_o("err_sticky", 3'd5, 0, 0, 0, 0, 0, 0, 1);
      end
      chk("err_ret", {16'd0, bus.o_retired}, 32'(exp_ret));
      bus.i_mem_ready = 1'b0;
      bus.i_ir_valid = 1'b0;

      #2;
      rst = 1'b0;
      #1;
      chk_o("async_rst_err", 3'd0, 0, 0, 0, 0, 0, 0, 0);
      chk("async_rst_ret", {16'd0, bus.o_retired}, 32'd0);
      exp_ret = 0;
      tick();
      rst = 1'b1;
      tick();
      chk_o("run_again", 3'd1, 0, 0, 0, 0, 0, 0, 0);

      // Taken branch
      bus.i_ir = 16'hD0FE;
      bus.i_ir_valid = 1'b1;
      bus.i_cond_pass = 1'b1;
      tick();
      bus.i_ir_valid = 1'b0;
      chk_o("br_state", 3'd3, 0, 0, 0, 0, 0, 0, 0);
      tick();
      exp_ret++;
      chk_o("br_taken", 3'd4, 0, 0, 0, 0, 1, 1, 0);
      chk("br_ret", {16'd0, bus.o_retired}, 32'(exp_ret));
      bus.i_ir_valid = 1'b1;
      tick();
      chk_o("flush2", 3'd4, 0, 0, 0, 0, 0, 1, 0);
      bus.i_ir_valid = 1'b0;
      tick();
      chk_o("flush_end", 3'd1, 0, 0, 0, 0, 0, 0, 0);
      chk("flush_ret", {16'd0, bus.o_retired}, 32'(exp_ret));

      // Not-taken branch
      bus.i_ir_valid = 1'b1;
      tick();
      bus.i_ir_valid = 1'b0;
      bus.i_cond_pass = 1'b0;
      chk_o("brnt_state", 3'd3, 0, 0, 0, 0, 0, 0, 0);
      tick();
      exp_ret++;
      chk_o("br_not_taken", 3'd1, 0, 0, 0, 0, 0, 0, 0);
      chk("brnt_ret", {16'd0, bus.o_retired}, 32'(exp_ret));

      // Undefined opcode, then async reset mid-ERR
      bus.i_ir = 16'hFFFF;
      bus.i_ir_valid = 1'b1;
      tick();
      bus.i_ir_valid = 1'b0;
      chk_o("undef_err", 3'd5, 0, 0, 0, 0, 0, 0, 1);
      #3;
      rst = 1'b0;
      #1;
      chk_o("undef_async_rst", 3'd0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      rst = 1'b1;
      tick();
      chk_o("run_wrap", 3'd1, 0, 0, 0, 0, 0, 0, 0);

      // Retired-counter wrap
      bus.i_ir = 16'h2005;
      bus.i_ir_valid = 1'b1;
      for (int unsigned i = 0; i < 65535; i++) begin
         @(posedge clk);
      end
      #1;
      chk("pre_wrap_ret", {16'd0, bus.o_retired}, 32'h0000_FFFF);
      chk_o("pre_wrap_rf", 3'd1, 0, 0, 1, 0, 0, 0, 0);
      bus.i_ir = 16'h2801;
      tick();
      bus.i_ir_valid = 1'b0;
      chk("wrap_ret", {16'd0, bus.o_retired}, 32'd0);
      chk_o("cmp_flags", 3'd1, 0, 0, 0, 1, 0, 0, 0);
      tick();
      chk_o("cmp_after", 3'd1, 0, 0, 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
